ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have parameter STAGES, default 4, which sets the number of control-word pipeline stages (legal range 2..8).
REQ-002 The block SHALL have parameter CW_WIDTH, default 32, which sets the width of the opaque control word.
REQ-003 The block SHALL have parameter OPC_WIDTH, default 4, which sets the opcode width.
REQ-004 The block SHALL have parameter ILLEGAL_MASK, 2**OPC_WIDTH bits, default 16'h0C00; bit n set means opcode n is illegal.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the decode stage presents an instruction.
REQ-008 The block SHALL have port in_opcode, input, OPC_WIDTH bits: opcode of the presented instruction.
REQ-009 The block SHALL have port in_ctrl, input, CW_WIDTH bits: decoded control word of the presented instruction.
REQ-010 The block SHALL have port in_ready, output, 1 bit: stage 0 accepts this cycle.
REQ-011 The block SHALL have port stall, input, STAGES bits: bit i requests that stage i hold.
REQ-012 The block SHALL have port flush, input, STAGES bits: bit i kills stage i and all younger stages.
REQ-013 The block SHALL have port stage_valid, output, STAGES bits: per-stage valid flag.
REQ-014 The block SHALL have port stage_ctrl, output, STAGES*CW_WIDTH bits: per-stage control words, stage i at bits [i*CW_WIDTH +: CW_WIDTH].
REQ-015 The block SHALL have port stage_opcode, output, STAGES*OPC_WIDTH bits: per-stage opcodes, packed the same way.
REQ-016 The block SHALL have port stage_illegal, output, STAGES bits: per-stage illegal-opcode flag.
REQ-017 The block SHALL have port retire_valid, output, 1 bit: the oldest stage leaves the pipe this cycle.
REQ-018 The block SHALL have port bubble_count, output, 16 bits: saturating count of empty retire slots.

Function
REQ-019 Stage 0 SHALL be the youngest stage and stage STAGES-1 the oldest; all outputs SHALL be driven directly from registers except in_ready and retire_valid.
REQ-020 The hold index h SHALL be the highest i with stall[i]=1; when stall is all zero, there is no hold.
REQ-021 Stages 0..h SHALL keep their contents, stage h+1 (if it exists) SHALL load a bubble (valid=0, ctrl=0, opcode=0, illegal=0), and stages above h+1 SHALL load from their younger neighbour.
REQ-022 The flush index f SHALL be the highest i with flush[i]=1; stages 0..f SHALL load a bubble, and flush SHALL take priority over stall and over input.
REQ-023 in_ready SHALL be 1 only when stall and flush are both all zero.
REQ-024 When in_ready=1 and in_valid=1, stage 0 SHALL load valid=1, in_opcode, and in_ctrl; when in_ready=1 and in_valid=0, stage 0 SHALL load a bubble.
REQ-025 An accepted opcode whose ILLEGAL_MASK bit is set SHALL load ctrl=0 and illegal=1 with valid=1 and the opcode retained; the illegal flag SHALL travel with the entry.
REQ-026 retire_valid SHALL equal stage_valid[STAGES-1] AND NOT stall[STAGES-1] AND NOT flush[STAGES-1].
REQ-027 bubble_count SHALL increment by 1 in each cycle where stage STAGES-1 is invalid and stall[STAGES-1]=0, and SHALL saturate at 16'hFFFF.
REQ-028 Latency from acceptance to retire_valid SHALL be exactly STAGES cycles when no stall or flush occurs.
REQ-029 A stall and a flush in the same cycle with h>f SHALL give: stages 0..f cleared, stages f+1..h held, stage h+1 bubbled.
REQ-030 An entry SHALL never be duplicated or dropped except through flush.

Reset
REQ-031 While rst=1, every stage SHALL load a bubble, bubble_count SHALL load 0, and input SHALL NOT be accepted; rst SHALL override stall and flush.
REQ-032 In the first cycle after rst deasserts, stage_valid, stage_ctrl, stage_opcode, stage_illegal, retire_valid and bubble_count SHALL all read 0, and in_ready SHALL follow REQ-023.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries within one cycle.

Verification (STAGES=4, CW_WIDTH=32)
REQ-034 The bench SHALL cover: opcode 4'h1 with ctrl 32'hDEAD_BEEF accepted at cycle 0 -> retire_valid=1 with stage_ctrl[3]=32'hDEAD_BEEF at cycle 4.
REQ-035 The bench SHALL cover: opcode 4'hA accepted -> the entry arrives with ctrl=0 and illegal=1 in every stage through retire.
REQ-036 The bench SHALL cover: stall=4'b0010 held for 2 cycles with stages full -> stages 0 and 1 hold, stage 2 gets bubbles, in_ready=0, bubble_count increments 2 cycles later.
REQ-037 The bench SHALL cover: flush=4'b0100 with all stages valid -> stages 0..2 invalid next cycle, stage 3 advances and retires.
REQ-038 The bench SHALL cover: rst asserted with a full pipe and stall=4'b1111 -> next cycle all stage_valid=0 and bubble_count=0.
REQ-039 The bench SHALL cover: 70000 consecutive idle cycles -> bubble_count=16'hFFFF and stays there.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline: per-stage valid/opcode/ctrl/illegal registers with
// stall (hold) and flush (kill) control, retire strobe and bubble counter.
module ctrl_pipeline #(
  parameter int STAGES    = 4,
  parameter int CW_WIDTH  = 32,
  parameter int OPC_WIDTH = 4,
  parameter logic [2**OPC_WIDTH-1:0] ILLEGAL_MASK = 16'h0C00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [OPC_WIDTH-1:0]          in_opcode,
  input  logic [CW_WIDTH-1:0]           in_ctrl,
  output logic                          in_ready,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             flush,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*CW_WIDTH-1:0]    stage_ctrl,
  output logic [STAGES*OPC_WIDTH-1:0]   stage_opcode,
  output logic [STAGES-1:0]             stage_illegal,
  output logic                          retire_valid,
  output logic [15:0]                   bubble_count
);

  logic                 valid_q [STAGES];
  logic [CW_WIDTH-1:0]  ctrl_q  [STAGES];
  logic [OPC_WIDTH-1:0] opc_q   [STAGES];
  logic                 ill_q   [STAGES];

  logic                 src_valid [STAGES];
  logic [CW_WIDTH-1:0]  src_ctrl  [STAGES];
  logic [OPC_WIDTH-1:0] src_opc   [STAGES];
  logic                 src_ill   [STAGES];

  logic has_hold, has_flush, in_bad;
  int   hold_idx, flush_idx;

  always_comb begin
    has_hold  = 1'b0;
    hold_idx  = 0;
    has_flush = 1'b0;
    flush_idx = 0;
    for (int i = 0; i < STAGES; i++) begin
      if (stall[i]) begin
        has_hold = 1'b1;
        hold_idx = i;
      end
      if (flush[i]) begin
        has_flush = 1'b1;
        flush_idx = i;
      end
    end
  end

  assign in_ready     = ~|stall & ~|flush;
  assign in_bad       = ILLEGAL_MASK[in_opcode];
  assign retire_valid = valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];

  // Shift sources; an entry killed by flush must not slip into the next stage.
  always_comb begin
    src_valid[0] = in_valid;
    src_opc[0]   = in_valid ? in_opcode : '0;
    src_ill[0]   = in_valid & in_bad;
    src_ctrl[0]  = (in_valid && !in_bad) ? in_ctrl : '0;
    for (int i = 1; i < STAGES; i++) begin
      if (has_flush && (i - 1) <= flush_idx) begin
        src_valid[i] = 1'b0;
        src_ctrl[i]  = '0;
        src_opc[i]   = '0;
        src_ill[i]   = 1'b0;
      end else begin
        src_valid[i] = valid_q[i-1];
        src_ctrl[i]  = ctrl_q[i-1];
        src_opc[i]   = opc_q[i-1];
        src_ill[i]   = ill_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst || (has_flush && i <= flush_idx) || (has_hold && i == hold_idx + 1)) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
        opc_q[i]   <= '0;
        ill_q[i]   <= 1'b0;
      end else if (!(has_hold && i <= hold_idx)) begin
        valid_q[i] <= src_valid[i];
        ctrl_q[i]  <= src_ctrl[i];
        opc_q[i]   <= src_opc[i];
        ill_q[i]   <= src_ill[i];
      end
    end
    if (rst)
      bubble_count <= '0;
    else if (!valid_q[STAGES-1] && !stall[STAGES-1] && bubble_count != 16'hFFFF)
      bubble_count <= bubble_count + 16'd1;
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_valid[i]                          = valid_q[i];
      stage_illegal[i]                        = ill_q[i];
      stage_ctrl[i*CW_WIDTH +: CW_WIDTH]      = ctrl_q[i];
      stage_opcode[i*OPC_WIDTH +: OPC_WIDTH]  = opc_q[i];
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized bench for ctrl_pipeline against an entry-level reference model
// (kill flushed entries, then move the surviving ones).
module tb_ctrl_pipeline;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   in_opcode = '0;
  logic [31:0]  in_ctrl = '0;
  logic         in_ready;
  logic [3:0]   stall = '0;
  logic [3:0]   flush = '0;
  logic [3:0]   stage_valid;
  logic [127:0] stage_ctrl;
  logic [15:0]  stage_opcode;
  logic [3:0]   stage_illegal;
  logic         retire_valid;
  logic [15:0]  bubble_count;

  ctrl_pipeline dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ctrl(in_ctrl), .in_ready(in_ready), .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .stage_opcode(stage_opcode),
    .stage_illegal(stage_illegal), .retire_valid(retire_valid), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  opc;
    logic [31:0] ctrl;
    logic        ill;
  } ent_t;

  localparam logic [15:0] MASK = 16'h0C00;

  ent_t m [4];
  logic [15:0] m_bc;
  bit   known = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic ent_t empty_ent();
    ent_t e;
    e = '0;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [3:0] o,
                            input logic [31:0] c, input logic [3:0] s, input logic [3:0] f);
    ent_t old [4];
    ent_t nxt [4];
    ent_t inp;
    int   h;
    if (r) begin
      for (int i = 0; i < 4; i++) m[i] = empty_ent();
      m_bc = 16'd0;
      return;
    end
    if (!m[3].v && !s[3] && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
    for (int i = 0; i < 4; i++) old[i] = m[i];
    for (int i = 0; i < 4; i++)
      if (f != 0 && (f >> i) != 0) old[i] = empty_ent();  // i <= highest flush bit
    inp = empty_ent();
    if (v && s == 0 && f == 0) begin
      inp.v   = 1'b1;
      inp.opc = o;
      inp.ill = MASK[o];
      inp.ctrl = MASK[o] ? 32'h0 : c;
    end
    h = -1;
    for (int i = 0; i < 4; i++) if (s[i]) h = i;
    for (int i = 0; i < 4; i++) begin
      if (i <= h)          nxt[i] = old[i];
      else if (i == h + 1) nxt[i] = (h >= 0) ? empty_ent() : inp;
      else                 nxt[i] = old[i-1];
    end
    for (int i = 0; i < 4; i++) m[i] = nxt[i];
  endtask

  task automatic check_regs();
    logic [3:0] ev, ei;
    logic [127:0] ec;
    logic [15:0] eo;
    for (int i = 0; i < 4; i++) begin
      ev[i] = m[i].v;
      ei[i] = m[i].ill;
      ec[i*32 +: 32] = m[i].ctrl;
      eo[i*4 +: 4] = m[i].opc;
    end
    chk("stage_valid", stage_valid, ev);
    chk("stage_ctrl", stage_ctrl, ec);
    chk("stage_opcode", stage_opcode, eo);
    chk("stage_illegal", stage_illegal, ei);
    chk("bubble_count", bubble_count, m_bc);
  endtask

  task automatic cycle(input bit r, input bit v, input logic [3:0] o,
                       input logic [31:0] c, input logic [3:0] s, input logic [3:0] f);
    rst = r; in_valid = v; in_opcode = o; in_ctrl = c; stall = s; flush = f;
    #1;
    if (known) begin
      if (!r) chk("in_ready", in_ready, (s == 0 && f == 0));
      chk("retire_valid", retire_valid, m[3].v & ~s[3] & ~f[3]);
    end
    @(posedge clk);
    model_step(r, v, o, c, s, f);
    known = 1'b1;
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 32'h0, 4'h0, 4'h0);
  endtask

  task automatic fill();
    for (int i = 0; i < 4; i++) cycle(0, 1, 4'h3 + 4'(i), 32'h1000_0000 + i, 4'h0, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m[i] = empty_ent();
    m_bc = 16'd0;

    cycle(1, 0, 4'h0, 32'h0, 4'h0, 4'h0);
    cycle(1, 1, 4'h5, 32'h1234_5678, 4'h0, 4'h0);
    chk("post_reset_valid", stage_valid, 4'h0);
    chk("post_reset_bc", bubble_count, 16'h0);
    #1;
    chk("post_reset_ready", in_ready, 1'b1);
    chk("post_reset_retire", retire_valid, 1'b0);

    // Latency: accept at cycle 0, retire visible 4 cycles later.
    cycle(0, 1, 4'h1, 32'hDEAD_BEEF, 4'h0, 4'h0);
    idle(3);
    #1;
    chk("lat_retire", retire_valid, 1'b1);
    chk("lat_ctrl3", stage_ctrl[127:96], 32'hDEAD_BEEF);
    idle(1);

    // Illegal opcode travels with ctrl cleared.
    cycle(0, 1, 4'hA, 32'hFFFF_FFFF, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("ill_flag", stage_illegal[i], 1'b1);
      chk("ill_ctrl", stage_ctrl[i*32 +: 32], 32'h0);
      chk("ill_opc", stage_opcode[i*4 +: 4], 4'hA);
      if (i < 3) idle(1);
    end
    #1;
    chk("ill_retire", retire_valid, 1'b1);
    idle(1);

    // Mid-stage stall for two cycles with a full pipe.
    fill();
    cycle(0, 1, 4'h7, 32'h7777_0000, 4'b0010, 4'h0);
    cycle(0, 1, 4'h7, 32'h7777_0001, 4'b0010, 4'h0);
    chk("stall_s2_bubble", stage_valid[2], 1'b0);
    chk("stall_s0_held", stage_opcode[3:0], 4'h6);
    idle(3);

    // Flush at stage 2 with a full pipe.
    fill();
    cycle(0, 0, 4'h0, 32'h0, 4'h0, 4'b0100);
    chk("flush_valid", stage_valid, 4'b0000);
    idle(2);

    // Stall and flush together (h > f).
    fill();
    cycle(0, 0, 4'h0, 32'h0, 4'b0100, 4'b0001);
    idle(2);

    // Reset overrides stall on a full pipe.
    fill();
    cycle(1, 0, 4'h0, 32'h0, 4'b1111, 4'h0);
    chk("rst_valid", stage_valid, 4'h0);
    chk("rst_bc", bubble_count, 16'h0);

    for (int n = 0; n < 3000; n++) begin
      bit          r, v;
      logic [3:0]  o, s, f;
      logic [31:0] c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = 4'($urandom);
      c = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      cycle(r, v, o, c, s, f);
    end

    // Saturation of the bubble counter.
    cycle(1, 0, 4'h0, 32'h0, 4'h0, 4'h0);
    idle(70000);
    chk("bc_saturated", bubble_count, 16'hFFFF);
    idle(3);
    chk("bc_stays", bubble_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
